// File: rtl/scarv_cop_mp_seq_pkg.sv
// Shared constants for the multi-precision add/subtract sequencer: MALU subclass
// bit positions and the sequencer state encoding.
package scarv_cop_mp_seq_pkg;

  // Bit positions of the three-operand add/sub subclasses in the MALU one-hot field.
  localparam int SCARV_COP_SCLASS_MADD_3 = 3;
  localparam int SCARV_COP_SCLASS_MSUB_3 = 4;

  localparam logic [15:0] MP_SUBCLASS_MADD = 16'(1) << SCARV_COP_SCLASS_MADD_3;
  localparam logic [15:0] MP_SUBCLASS_MSUB = 16'(1) << SCARV_COP_SCLASS_MSUB_3;

  typedef logic [2:0] mp_state_t;

  localparam mp_state_t ST_IDLE = 3'd0;
  localparam mp_state_t ST_RD_A = 3'd1;
  localparam mp_state_t ST_RD_B = 3'd2;
  localparam mp_state_t ST_EXEC = 3'd3;
  localparam mp_state_t ST_WR   = 3'd4;
  localparam mp_state_t ST_DONE = 3'd5;

endpackage

// File: rtl/scarv_cop_mp_seq.sv
// Multi-precision add/subtract sequencer: reads A[i], B[i], runs madd_3/msub_3
// on the MALU with the running carry/borrow, writes R[i], reports the final carry.
//
// Handshakes (req_*, done_*): a transfer happens on a rising g_clk edge where
// valid && ready are both high; a producer holds valid and its payload stable
// until that edge, and ready never depends combinationally on valid.
module scarv_cop_mp_seq
  import scarv_cop_mp_seq_pkg::*;
#(
  parameter int AW = 6,
  parameter int LW = 6
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_sub,
  input  logic          req_cin,
  input  logic [LW-1:0] req_len,
  input  logic [AW-1:0] req_a_base,
  input  logic [AW-1:0] req_b_base,
  input  logic [AW-1:0] req_r_base,
  output logic          done_valid,
  input  logic          done_ready,
  output logic          done_carry,
  output logic          mem_ren,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          malu_ivalid,
  output logic [15:0]   malu_subclass,
  output logic [31:0]   malu_rs1,
  output logic [31:0]   malu_rs2,
  output logic [31:0]   malu_rs3,
  input  logic          malu_idone,
  input  logic [3:0]    malu_ben,
  input  logic [31:0]   malu_wdata,
  output mp_state_t     dbg_state
);

  mp_state_t     state_q, state_d;
  logic          op_sub_q;
  logic          carry_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx_q;
  logic [AW-1:0] a_base_q, b_base_q, r_base_q;
  logic [31:0]   a_q, b_q, lo_q;
  logic          hi_carry_q;
  logic          exec_first_q;
  logic          last_limb;

  assign last_limb = (idx_q == len_q - LW'(1));
  assign dbg_state = state_q;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = (req_len == '0) ? ST_DONE : ST_RD_A;
      ST_RD_A: state_d = ST_RD_B;
      ST_RD_B: state_d = ST_EXEC;
      ST_EXEC: if (malu_idone) state_d = ST_WR;
      ST_WR:   state_d = last_limb ? ST_DONE : ST_RD_A;
      ST_DONE: if (done_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = 1'b0;
    done_valid    = 1'b0;
    done_carry    = 1'b0;
    mem_ren       = 1'b0;
    mem_raddr     = a_base_q + AW'(idx_q);
    mem_wen       = 1'b0;
    mem_waddr     = r_base_q + AW'(idx_q);
    mem_wdata     = lo_q;
    malu_ivalid   = 1'b0;
    malu_subclass = '0;
    malu_rs1      = a_q;
    // B arrives from memory on the first EXEC cycle; forward it so rs2 is valid immediately.
    malu_rs2      = exec_first_q ? mem_rdata : b_q;
    malu_rs3      = {31'b0, carry_q};
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_RD_A: mem_ren = 1'b1;
      ST_RD_B: begin
        mem_ren   = 1'b1;
        mem_raddr = b_base_q + AW'(idx_q);
      end
      ST_EXEC: begin
        malu_ivalid   = 1'b1;
        malu_subclass = op_sub_q ? MP_SUBCLASS_MSUB : MP_SUBCLASS_MADD;
      end
      ST_WR:   mem_wen = 1'b1;
      ST_DONE: begin
        done_valid = 1'b1;
        done_carry = carry_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      op_sub_q     <= 1'b0;
      carry_q      <= 1'b0;
      len_q        <= '0;
      idx_q        <= '0;
      a_base_q     <= '0;
      b_base_q     <= '0;
      r_base_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      lo_q         <= '0;
      hi_carry_q   <= 1'b0;
      exec_first_q <= 1'b0;
    end else begin
      exec_first_q <= (state_q == ST_RD_B);
      case (state_q)
        ST_IDLE: if (req_valid) begin
          op_sub_q <= req_sub;
          carry_q  <= req_cin;
          len_q    <= req_len;
          idx_q    <= '0;
          a_base_q <= req_a_base;
          b_base_q <= req_b_base;
          r_base_q <= req_r_base;
        end
        ST_RD_B: a_q <= mem_rdata;
        ST_EXEC: begin
          if (exec_first_q) b_q <= mem_rdata;
          if ((malu_ben != 4'b0) && !malu_idone) lo_q <= malu_wdata;
          // The hi word is all-ones on borrow or 1 on carry, so bit 0 is the next carry.
          if (malu_idone) hi_carry_q <= malu_wdata[0];
        end
        ST_WR: begin
          carry_q <= hi_carry_q;
          idx_q   <= idx_q + LW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scarv_cop_mp_seq.sv
// Bench for scarv_cop_mp_seq: word memory and 3-cycle MALU models around the DUT,
// limb-level arithmetic reference on a shadow memory image.
module tb_scarv_cop_mp_seq;
  import scarv_cop_mp_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  logic        req_valid = 1'b0, req_ready, req_sub = 1'b0, req_cin = 1'b0;
  logic [5:0]  req_len = '0, req_a_base = '0, req_b_base = '0, req_r_base = '0;
  logic        done_valid, done_ready = 1'b0, done_carry;
  logic        mem_ren, mem_wen;
  logic [5:0]  mem_raddr, mem_waddr;
  logic [31:0] mem_rdata, mem_wdata;
  logic        malu_ivalid, malu_idone;
  logic [15:0] malu_subclass;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3, malu_wdata;
  logic [3:0]  malu_ben;
  mp_state_t   dbg_state;

  scarv_cop_mp_seq #(.AW(6), .LW(6)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub), .req_cin(req_cin),
    .req_len(req_len), .req_a_base(req_a_base), .req_b_base(req_b_base), .req_r_base(req_r_base),
    .done_valid(done_valid), .done_ready(done_ready), .done_carry(done_carry),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .malu_ivalid(malu_ivalid), .malu_subclass(malu_subclass),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_idone(malu_idone), .malu_ben(malu_ben), .malu_wdata(malu_wdata),
    .dbg_state(dbg_state)
  );

  // ---------------- environment models ----------------
  logic [31:0] mem [64];
  logic        tb_we = 1'b0;
  logic [5:0]  tb_waddr = '0;
  logic [31:0] tb_wdata = '0;
  logic [5:0]  log_addr [4096];
  int          wr_cnt = 0, ren_cnt = 0, iv_cnt = 0, sc_err = 0;
  logic        cur_sub = 1'b0;

  always @(posedge g_clk) begin
    if (mem_ren) begin
      mem_rdata <= mem[mem_raddr];
      ren_cnt   <= ren_cnt + 1;
    end
    if (mem_wen) begin
      mem[mem_waddr]         <= mem_wdata;
      log_addr[wr_cnt % 4096] <= mem_waddr;
      wr_cnt                 <= wr_cnt + 1;
    end
    if (tb_we) mem[tb_waddr] <= tb_wdata;
  end

  logic [1:0]  malu_cnt = 2'd0;
  logic [63:0] malu_res;
  always_comb begin
    if (malu_subclass[SCARV_COP_SCLASS_MSUB_3])
      malu_res = {32'b0, malu_rs1} - {32'b0, malu_rs2} - {32'b0, malu_rs3};
    else
      malu_res = {32'b0, malu_rs1} + {32'b0, malu_rs2} + {32'b0, malu_rs3};
    malu_ben   = (malu_ivalid && malu_cnt == 2'd1) ? 4'hF : 4'h0;
    malu_idone = malu_ivalid && (malu_cnt == 2'd2);
    malu_wdata = (malu_cnt == 2'd2) ? malu_res[63:32] : malu_res[31:0];
  end

  always @(posedge g_clk) begin
    if (!malu_ivalid || malu_idone) malu_cnt <= 2'd0;
    else                            malu_cnt <= malu_cnt + 2'd1;
    if (malu_ivalid) begin
      iv_cnt <= iv_cnt + 1;
      if (malu_subclass !== (cur_sub ? MP_SUBCLASS_MSUB : MP_SUBCLASS_MADD)) sc_err <= sc_err + 1;
    end
  end

  // ---------------- scoreboard / reference ----------------
  logic [31:0] shadow [64];
  logic [5:0]  exp_q[$];
  int          n_pass = 0, n_total = 0;

  task automatic ref_run(input logic sub, input logic cin, input logic [5:0] len,
                         input logic [5:0] ab, input logic [5:0] bb, input logic [5:0] rb,
                         output logic carry);
    logic        c;
    logic [32:0] t;
    logic [5:0]  o, aa, ba, ra;
    c = cin;
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      o  = 6'(i);
      aa = ab + o;
      ba = bb + o;
      ra = rb + o;
      if (sub) t = {1'b0, shadow[aa]} - {1'b0, shadow[ba]} - {32'b0, c};
      else     t = {1'b0, shadow[aa]} + {1'b0, shadow[ba]} + {32'b0, c};
      shadow[ra] = t[31:0];
      c = t[32];
      exp_q.push_back(ra);
    end
    carry = c;
  endtask

  function automatic int img_diffs();
    int n = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== shadow[i]) n++;
    return n;
  endfunction

  function automatic int addr_diffs(input int w0);
    int n = 0;
    for (int k = 0; k < exp_q.size(); k++)
      if (log_addr[(w0 + k) % 4096] !== exp_q[k]) n++;
    return n;
  endfunction

  // ---------------- drivers ----------------
  task automatic load_word(input logic [5:0] a, input logic [31:0] d);
    @(negedge g_clk);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    shadow[a] = d;
    @(posedge g_clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic send_req(input logic sub, input logic cin, input logic [5:0] len,
                          input logic [5:0] ab, input logic [5:0] bb, input logic [5:0] rb);
    @(negedge g_clk);
    cur_sub = sub;
    req_valid = 1'b1; req_sub = sub; req_cin = cin; req_len = len;
    req_a_base = ab; req_b_base = bb; req_r_base = rb;
    @(posedge g_clk);
    #1 req_valid = 1'b0;
  endtask

  // Returns the cycle count from accept to done_valid (bounded at 500).
  task automatic do_cmd(input logic sub, input logic cin, input logic [5:0] len,
                        input logic [5:0] ab, input logic [5:0] bb, input logic [5:0] rb,
                        output logic carry, output int lat);
    send_req(sub, cin, len, ab, bb, rb);
    lat = 0;
    while (lat < 500) begin
      @(negedge g_clk);
      lat++;
      if (done_valid) break;
    end
    carry = done_carry;
    done_ready = 1'b1;
    @(posedge g_clk);
    #1 done_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    g_resetn = 1'b0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    n_total++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready); else n_pass++;
    n_total++; if ({done_valid, done_carry} !== 2'b00) $display("FAIL reset_done: got %b expected 00", {done_valid, done_carry}); else n_pass++;
    n_total++; if ({mem_ren, mem_wen, malu_ivalid} !== 3'b000) $display("FAIL reset_enables: got %b expected 000", {mem_ren, mem_wen, malu_ivalid}); else n_pass++;
    n_total++; if (malu_subclass !== 16'h0) $display("FAIL reset_subclass: got %h expected 0000", malu_subclass); else n_pass++;
    g_resetn = 1'b1;
  endtask

  task automatic test_add_single();
    logic c, ec; int lat;
    load_word(6'd0, 32'hFFFF_FFFF);
    load_word(6'd1, 32'h0000_0001);
    ref_run(1'b0, 1'b0, 6'd1, 6'd0, 6'd1, 6'd2, ec);
    do_cmd(1'b0, 1'b0, 6'd1, 6'd0, 6'd1, 6'd2, c, lat);
    n_total++; if (mem[2] !== 32'h0) $display("FAIL add1_result: got %h expected 00000000", mem[2]); else n_pass++;
    n_total++; if (c !== 1'b1) $display("FAIL add1_carry: got %b expected 1", c); else n_pass++;
    n_total++; if (lat != 7) $display("FAIL add1_latency: got %0d expected 7", lat); else n_pass++;
    n_total++; if (img_diffs() != 0) $display("FAIL add1_image: got %0d differing words expected 0", img_diffs()); else n_pass++;
  endtask

  task automatic test_add_carry_chain();
    logic c, ec; int lat, w0, nz;
    for (int i = 0; i < 4; i++) begin
      load_word(6'(8 + i), 32'hFFFF_FFFF);
      load_word(6'(12 + i), 32'h0);
    end
    ref_run(1'b0, 1'b1, 6'd4, 6'd8, 6'd12, 6'd16, ec);
    w0 = wr_cnt;
    do_cmd(1'b0, 1'b1, 6'd4, 6'd8, 6'd12, 6'd16, c, lat);
    nz = 0;
    for (int i = 16; i < 20; i++) if (mem[i] !== 32'h0) nz++;
    n_total++; if (nz != 0) $display("FAIL add4_results: got %0d nonzero limbs expected 0", nz); else n_pass++;
    n_total++; if (c !== 1'b1) $display("FAIL add4_carry: got %b expected 1", c); else n_pass++;
    n_total++; if (wr_cnt - w0 != 4) $display("FAIL add4_write_count: got %0d expected 4", wr_cnt - w0); else n_pass++;
    n_total++; if (addr_diffs(w0) != 0) $display("FAIL add4_write_addrs: got %0d wrong addresses expected 0", addr_diffs(w0)); else n_pass++;
    n_total++; if (lat != 25) $display("FAIL add4_latency: got %0d expected 25", lat); else n_pass++;
  endtask

  task automatic test_sub();
    logic c, ec; int lat;
    load_word(6'd20, 32'h0000_0000);
    load_word(6'd21, 32'h0000_0001);
    load_word(6'd22, 32'h0000_0001);
    load_word(6'd23, 32'h0000_0000);
    ref_run(1'b1, 1'b0, 6'd2, 6'd20, 6'd22, 6'd24, ec);
    do_cmd(1'b1, 1'b0, 6'd2, 6'd20, 6'd22, 6'd24, c, lat);
    n_total++; if ({mem[25], mem[24]} !== 64'h0000_0000_FFFF_FFFF) $display("FAIL sub2_result: got %h_%h expected 00000000_ffffffff", mem[25], mem[24]); else n_pass++;
    n_total++; if (c !== 1'b0) $display("FAIL sub2_borrow: got %b expected 0", c); else n_pass++;
    load_word(6'd26, 32'h0);
    load_word(6'd27, 32'h1);
    ref_run(1'b1, 1'b0, 6'd1, 6'd26, 6'd27, 6'd28, ec);
    do_cmd(1'b1, 1'b0, 6'd1, 6'd26, 6'd27, 6'd28, c, lat);
    n_total++; if (mem[28] !== 32'hFFFF_FFFF) $display("FAIL sub1_result: got %h expected ffffffff", mem[28]); else n_pass++;
    n_total++; if (c !== 1'b1) $display("FAIL sub1_borrow: got %b expected 1", c); else n_pass++;
    n_total++; if (sc_err != 0) $display("FAIL subclass: got %0d bad cycles expected 0", sc_err); else n_pass++;
  endtask

  task automatic test_len_zero();
    logic c; int lat, r0, w0, i0;
    r0 = ren_cnt; w0 = wr_cnt; i0 = iv_cnt;
    do_cmd(1'b0, 1'b1, 6'd0, 6'd5, 6'd6, 6'd7, c, lat);
    repeat (3) @(negedge g_clk);
    n_total++; if (lat != 1) $display("FAIL len0_latency: got %0d expected 1", lat); else n_pass++;
    n_total++; if (c !== 1'b1) $display("FAIL len0_carry: got %b expected 1", c); else n_pass++;
    n_total++; if ((ren_cnt - r0) + (wr_cnt - w0) + (iv_cnt - i0) != 0)
      $display("FAIL len0_activity: got ren=%0d wen=%0d ivalid=%0d expected 0", ren_cnt - r0, wr_cnt - w0, iv_cnt - i0); else n_pass++;
  endtask

  task automatic test_inplace_wrap();
    logic c, ec; int lat, w0;
    for (int i = 0; i < 4; i++) begin
      load_word(6'h3E + 6'(i), $urandom);
      load_word(6'h10 + 6'(i), $urandom);
    end
    ref_run(1'b0, 1'b0, 6'd4, 6'h3E, 6'h10, 6'h3E, ec);
    w0 = wr_cnt;
    do_cmd(1'b0, 1'b0, 6'd4, 6'h3E, 6'h10, 6'h3E, c, lat);
    n_total++; if (addr_diffs(w0) != 0 || wr_cnt - w0 != 4) $display("FAIL wrap_addrs: got %0d writes %0d wrong expected 4 writes 0 wrong", wr_cnt - w0, addr_diffs(w0)); else n_pass++;
    n_total++; if (log_addr[(w0 + 2) % 4096] !== 6'h00) $display("FAIL wrap_third_addr: got %h expected 00", log_addr[(w0 + 2) % 4096]); else n_pass++;
    n_total++; if (img_diffs() != 0) $display("FAIL wrap_image: got %0d differing words expected 0", img_diffs()); else n_pass++;
    n_total++; if (c !== ec) $display("FAIL wrap_carry: got %b expected %b", c, ec); else n_pass++;
  endtask

  task automatic test_random();
    logic c, ec, sub, cin; logic [5:0] len, ab, bb, rb; int lat, w0;
    for (int t = 0; t < 10; t++) begin
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      len = 6'((t == 9) ? 12 : $urandom_range(1, 6));
      ab = 6'($urandom_range(0, 63));
      bb = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      ref_run(sub, cin, len, ab, bb, rb, ec);
      w0 = wr_cnt;
      do_cmd(sub, cin, len, ab, bb, rb, c, lat);
      n_total++; if (c !== ec) $display("FAIL rand%0d_carry: got %b expected %b", t, c, ec); else n_pass++;
      n_total++; if (img_diffs() != 0) $display("FAIL rand%0d_image: got %0d differing words expected 0", t, img_diffs()); else n_pass++;
      n_total++; if (lat != 6 * int'(len) + 1) $display("FAIL rand%0d_latency: got %0d expected %0d", t, lat, 6 * int'(len) + 1); else n_pass++;
      n_total++; if (addr_diffs(w0) != 0) $display("FAIL rand%0d_write_addrs: got %0d wrong expected 0", t, addr_diffs(w0)); else n_pass++;
    end
    n_total++; if (sc_err != 0) $display("FAIL rand_subclass: got %0d bad cycles expected 0", sc_err); else n_pass++;
  endtask

  task automatic test_done_hold();
    logic ec; int waited, bad_v, bad_c, bad_r;
    load_word(6'd40, 32'hFFFF_FFFF);
    load_word(6'd41, 32'hFFFF_FFFF);
    ref_run(1'b0, 1'b0, 6'd1, 6'd40, 6'd41, 6'd42, ec);
    send_req(1'b0, 1'b0, 6'd1, 6'd40, 6'd41, 6'd42);
    waited = 0;
    while (waited < 50) begin
      @(negedge g_clk);
      waited++;
      if (done_valid) break;
    end
    n_total++; if (done_valid !== 1'b1) $display("FAIL hold_done_timeout: got %b expected 1", done_valid); else n_pass++;
    bad_v = 0; bad_c = 0; bad_r = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge g_clk);
      if (done_valid !== 1'b1) bad_v++;
      if (done_carry !== ec) bad_c++;
      if (req_ready !== 1'b0) bad_r++;
    end
    n_total++; if (bad_v != 0) $display("FAIL hold_valid: got %0d drops expected 0", bad_v); else n_pass++;
    n_total++; if (bad_c != 0) $display("FAIL hold_carry: got %0d wrong cycles expected 0 (carry %b)", bad_c, ec); else n_pass++;
    n_total++; if (bad_r != 0) $display("FAIL hold_req_ready: got %0d high cycles expected 0", bad_r); else n_pass++;
    done_ready = 1'b1;
    @(posedge g_clk);
    #1 done_ready = 1'b0;
    @(negedge g_clk);
    n_total++; if (req_ready !== 1'b1 || done_valid !== 1'b0) $display("FAIL hold_release: got ready=%b valid=%b expected 1 0", req_ready, done_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_exec();
    logic ec; int lat, w0;
    for (int i = 0; i < 4; i++) begin
      load_word(6'h20 + 6'(i), $urandom);
      load_word(6'h28 + 6'(i), $urandom);
    end
    ref_run(1'b0, 1'b0, 6'd2, 6'h20, 6'h28, 6'h30, ec);
    w0 = wr_cnt;
    send_req(1'b0, 1'b0, 6'd4, 6'h20, 6'h28, 6'h30);
    lat = 0;
    repeat (15) begin
      @(negedge g_clk);
      lat++;
    end
    n_total++; if (dbg_state !== ST_EXEC) $display("FAIL rst_mid_in_exec: got %0d expected %0d", dbg_state, ST_EXEC); else n_pass++;
    g_resetn = 1'b0;
    @(posedge g_clk);
    #1 g_resetn = 1'b1;
    @(negedge g_clk);
    n_total++; if (dbg_state !== ST_IDLE) $display("FAIL rst_mid_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
    n_total++; if (req_ready !== 1'b1 || done_valid !== 1'b0) $display("FAIL rst_mid_handshake: got ready=%b valid=%b expected 1 0", req_ready, done_valid); else n_pass++;
    repeat (20) @(negedge g_clk);
    n_total++; if (wr_cnt - w0 != 2) $display("FAIL rst_mid_writes: got %0d expected 2", wr_cnt - w0); else n_pass++;
    n_total++; if (img_diffs() != 0) $display("FAIL rst_mid_image: got %0d differing words expected 0", img_diffs()); else n_pass++;
  endtask

  // ---------------- sequence ----------------
  initial begin
    test_reset();
    for (int i = 0; i < 64; i++) load_word(6'(i), $urandom);
    test_add_single();
    test_add_carry_chain();
    test_sub();
    test_len_zero();
    test_inplace_wrap();
    test_random();
    test_done_hold();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
